updown_counter_bank: RTL and testbench

Parametrised bank of independent up/down counters sharing one clock. Each channel has its own enable, synchronous load, count mode (up, down, bounce, hold) and wrap-or-saturate policy, plus a registered terminal-count pulse and direction flag. It extends the fixed two-channel 4-bit up/down counter pair to arbitrary width and channel count. It sits in the timing/sequencing layer, feeding display, PWM and event logic.

---
 rtl/updown_counter_pkg.sv | 13 +
 rtl/updown_counter_chan.sv | 100 ++++++++++
 rtl/updown_counter_bank.sv | 42 ++++
 tb/tb_updown_counter_bank.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/updown_counter_pkg.sv
// Shared definitions for the up/down counter bank.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package updown_counter_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_UP     = 2'b00;
    localparam mode_t MODE_DOWN   = 2'b01;
    localparam mode_t MODE_BOUNCE = 2'b10;
    localparam mode_t MODE_HOLD   = 2'b11;

endpackage

// File: rtl/updown_counter_chan.sv
// One up/down/bounce counter channel with load, wrap/saturate and terminal-count pulse.
// Latency: 1 cycle, all outputs registered.
// Backpressure: none; a step is taken on every enabled edge.
module updown_counter_chan
    import updown_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter bit RST_DOWN = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic             sat_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             dir_o
);

    localparam logic [WIDTH-1:0] MAX  = '1;
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             tc_q, tc_d;
    logic             step_up;

    // Next-state: load beats step; tc only when a step moves the count onto its terminal value.
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        tc_d    = 1'b0;
        step_up = dir_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (mode_i != MODE_HOLD)) begin
            case (mode_i)
                MODE_UP: begin
                    dir_d = 1'b1;
                    if (count_q == MAX) begin
                        count_d = sat_i ? MAX : ZERO;
                    end else begin
                        count_d = count_q + ONE;
                    end
                    // Only an increment from MAX-1 arrives at MAX; a saturated hold does not re-pulse.
                    tc_d = (count_q == (MAX - ONE));
                end
                MODE_DOWN: begin
                    dir_d = 1'b0;
                    if (count_q == ZERO) begin
                        count_d = sat_i ? ZERO : MAX;
                    end else begin
                        count_d = count_q - ONE;
                    end
                    tc_d = (count_q == ONE);
                end
                MODE_BOUNCE: begin
                    // Sitting on a bound while pointing outward: turn around before stepping.
                    if (count_q == MAX) begin
                        step_up = 1'b0;
                    end else if (count_q == ZERO) begin
                        step_up = 1'b1;
                    end
                    count_d = step_up ? (count_q + ONE) : (count_q - ONE);
                    if (count_d == MAX) begin
                        dir_d = 1'b0;
                    end else if (count_d == ZERO) begin
                        dir_d = 1'b1;
                    end else begin
                        dir_d = step_up;
                    end
                    tc_d = (count_d == MAX) || (count_d == ZERO);
                end
                default: begin
                end
            endcase
        end
    end

    // State registers with synchronous reset to the per-channel initial direction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= RST_DOWN ? MAX : ZERO;
            dir_q   <= ~RST_DOWN;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            tc_q    <= tc_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;
    assign dir_o   = dir_q;

endmodule

// File: rtl/updown_counter_bank.sv
// Bank of independent up/down counters; slices the packed vectors per channel.
// Latency: 1 cycle, all outputs registered.
// Backpressure: none.
module updown_counter_bank
    import updown_counter_pkg::*;
#(
    parameter int                  WIDTH     = 4,
    parameter int                  CHANNELS  = 2,
    parameter logic [CHANNELS-1:0] DOWN_INIT = 2'b10
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [CHANNELS-1:0]       en_i,
    input  logic [2*CHANNELS-1:0]     mode_i,
    input  logic [CHANNELS-1:0]       sat_i,
    input  logic [CHANNELS-1:0]       load_i,
    input  logic [WIDTH*CHANNELS-1:0] load_val_i,
    output logic [WIDTH*CHANNELS-1:0] count_o,
    output logic [CHANNELS-1:0]       tc_o,
    output logic [CHANNELS-1:0]       dir_o
);

    // One channel per slice; channels share only the clock and reset.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        updown_counter_chan #(
            .WIDTH    (WIDTH),
            .RST_DOWN (DOWN_INIT[i])
        ) u_chan (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .en_i       (en_i[i]),
            .mode_i     (mode_i[2*i +: 2]),
            .sat_i      (sat_i[i]),
            .load_i     (load_i[i]),
            .load_val_i (load_val_i[WIDTH*i +: WIDTH]),
            .count_o    (count_o[WIDTH*i +: WIDTH]),
            .tc_o       (tc_o[i]),
            .dir_o      (dir_o[i])
        );
    end

endmodule

// File: tb/tb_updown_counter_bank.sv
// Self-checking bench for updown_counter_bank against a behavioural per-channel model.
// Latency: outputs checked 1 ns after each rising edge.
// Backpressure: n/a.
module tb_updown_counter_bank;

    localparam int              W    = 4;
    localparam int              CH   = 2;
    localparam logic [CH-1:0]   DI   = 2'b10;
    localparam int              MAXV = (1 << W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH-1:0]     en, sat, load;
    logic [2*CH-1:0]   mode;
    logic [W*CH-1:0]   load_val;
    logic [W*CH-1:0]   count_o;
    logic [CH-1:0]     tc_o, dir_o;

    always #5 clk = ~clk;

    updown_counter_bank #(.WIDTH(W), .CHANNELS(CH), .DOWN_INIT(DI)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .mode_i     (mode),
        .sat_i      (sat),
        .load_i     (load),
        .load_val_i (load_val),
        .count_o    (count_o),
        .tc_o       (tc_o),
        .dir_o      (dir_o)
    );

    // Reference state per channel
    int  m_cnt [CH];
    bit  m_dir [CH];
    bit  m_tc  [CH];

    logic [W*CH-1:0] exp_count;
    logic [CH-1:0]   exp_dir, exp_tc;

    int vectors     = 0;
    int miscompares = 0;

    // Advance one edge: apply the behavioural rules to the inputs present at that edge.
    task automatic tick();
        int nxt, stp, md;
        @(posedge clk);
        for (int c = 0; c < CH; c++) begin
            md = int'(mode[2*c +: 2]);
            if (rst) begin
                m_cnt[c] = DI[c] ? MAXV : 0;
                m_dir[c] = !DI[c];
                m_tc[c]  = 0;
            end else if (load[c]) begin
                m_cnt[c] = int'(load_val[c*W +: W]);
                m_tc[c]  = 0;
            end else if (en[c] && md != 3) begin
                if (md == 0) begin
                    nxt = (m_cnt[c] == MAXV) ? (sat[c] ? MAXV : 0) : m_cnt[c] + 1;
                    m_tc[c]  = (nxt == MAXV) && (m_cnt[c] != MAXV);
                    m_dir[c] = 1;
                end else if (md == 1) begin
                    nxt = (m_cnt[c] == 0) ? (sat[c] ? 0 : MAXV) : m_cnt[c] - 1;
                    m_tc[c]  = (nxt == 0) && (m_cnt[c] != 0);
                    m_dir[c] = 0;
                end else begin
                    stp = m_dir[c] ? 1 : -1;
                    if (m_cnt[c] + stp > MAXV || m_cnt[c] + stp < 0) stp = -stp;
                    nxt = m_cnt[c] + stp;
                    m_dir[c] = (nxt == MAXV) ? 0 : (nxt == 0) ? 1 : (stp > 0);
                    m_tc[c]  = (nxt == 0) || (nxt == MAXV);
                end
                m_cnt[c] = nxt;
            end else begin
                m_tc[c] = 0;
            end
        end
        #1;
        for (int c = 0; c < CH; c++) begin
            exp_count[c*W +: W] = W'(m_cnt[c]);
            exp_dir[c]          = m_dir[c];
            exp_tc[c]           = m_tc[c];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = '0; mode = '0; sat = '0; load = '0; load_val = '0;
        tick();
        tick();
        vectors++;
        if (count_o !== exp_count || dir_o !== exp_dir || tc_o !== exp_tc) begin
            miscompares++;
            $display("FAIL reset_model: count=%h dir=%b tc=%b, want count=%h dir=%b tc=%b",
                     count_o, dir_o, tc_o, exp_count, exp_dir, exp_tc);
        end
        vectors++;
        if (count_o !== 8'hF0 || dir_o !== 2'b01 || tc_o !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_values: count=%h dir=%b tc=%b, want count=f0 dir=01 tc=00",
                     count_o, dir_o, tc_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        en = 2'b11; mode = 4'b0100; sat = 2'b00; load = '0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            vectors++;
            if (count_o !== exp_count || dir_o !== exp_dir || tc_o !== exp_tc) begin
                miscompares++;
                $display("FAIL wrap_model[%0d]: count=%h dir=%b tc=%b, want count=%h dir=%b tc=%b",
                         i, count_o, dir_o, tc_o, exp_count, exp_dir, exp_tc);
            end
            vectors++;
            if (count_o[3:0] !== 4'(i % 16) || count_o[7:4] !== 4'((31 - i) % 16) ||
                tc_o !== ((i == 15) ? 2'b11 : 2'b00)) begin
                miscompares++;
                $display("FAIL wrap_seq[%0d]: count=%h tc=%b, want count0=%0d count1=%0d tc=%b",
                         i, count_o, tc_o, i % 16, (31 - i) % 16, (i == 15) ? 2'b11 : 2'b00);
            end
        end
    endtask

    task automatic test_saturate();
        int pulses = 0;
        logic [3:0] c1;
        c1 = count_o[7:4];
        en = 2'b11; mode = 4'b1100; sat = 2'b01; load = '0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (tc_o[0] === 1'b1) pulses++;
            vectors++;
            if (count_o !== exp_count || dir_o !== exp_dir || tc_o !== exp_tc) begin
                miscompares++;
                $display("FAIL sat_model[%0d]: count=%h dir=%b tc=%b, want count=%h dir=%b tc=%b",
                         i, count_o, dir_o, tc_o, exp_count, exp_dir, exp_tc);
            end
        end
        vectors++;
        if (count_o[3:0] !== 4'd15 || pulses != 1 || count_o[7:4] !== c1) begin
            miscompares++;
            $display("FAIL sat_stick: count0=%0d pulses=%0d count1=%0d, want 15 1 %0d",
                     count_o[3:0], pulses, count_o[7:4], c1);
        end
    endtask

    task automatic test_bounce();
        int exp_a [4] = '{14, 15, 14, 13};
        bit tc_a  [4] = '{0, 1, 0, 0};
        bit dir_a [4] = '{1, 0, 0, 0};
        int exp_b [3] = '{1, 0, 1};
        bit tc_b  [3] = '{0, 1, 0};
        bit dir_b [3] = '{0, 1, 1};
        sat = '0; en = 2'b11; mode = 4'b1100;
        load = 2'b01; load_val = {4'd0, 4'd13};
        tick();
        load = '0; mode = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (count_o !== exp_count || dir_o !== exp_dir || tc_o !== exp_tc ||
                count_o[3:0] !== 4'(exp_a[i]) || tc_o[0] !== tc_a[i] || dir_o[0] !== dir_a[i]) begin
                miscompares++;
                $display("FAIL bounce_top[%0d]: count0=%0d dir0=%b tc0=%b, want %0d %b %b",
                         i, count_o[3:0], dir_o[0], tc_o[0], exp_a[i], dir_a[i], tc_a[i]);
            end
        end
        load = 2'b01; load_val = {4'd0, 4'd2};
        tick();
        load = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (count_o !== exp_count || dir_o !== exp_dir || tc_o !== exp_tc ||
                count_o[3:0] !== 4'(exp_b[i]) || tc_o[0] !== tc_b[i] || dir_o[0] !== dir_b[i]) begin
                miscompares++;
                $display("FAIL bounce_bottom[%0d]: count0=%0d dir0=%b tc0=%b, want %0d %b %b",
                         i, count_o[3:0], dir_o[0], tc_o[0], exp_b[i], dir_b[i], tc_b[i]);
            end
        end
    endtask

    task automatic test_load_priority();
        int vals [2] = '{7, 15};
        en = 2'b11; mode = 4'b1100; sat = '0; load = '0;
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            load = 2'b01; load_val = {4'd0, 4'(vals[i])};
            tick();
            vectors++;
            if (count_o !== exp_count || tc_o !== exp_tc ||
                count_o[3:0] !== 4'(vals[i]) || tc_o[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL load_prio[%0d]: count0=%0d tc0=%b, want %0d 0",
                         i, count_o[3:0], tc_o[0], vals[i]);
            end
        end
        load = '0;
        tick();
        vectors++;
        if (count_o !== exp_count || dir_o !== exp_dir || tc_o !== exp_tc) begin
            miscompares++;
            $display("FAIL load_then_wrap: count=%h dir=%b tc=%b, want count=%h dir=%b tc=%b",
                     count_o, dir_o, tc_o, exp_count, exp_dir, exp_tc);
        end
    endtask

    task automatic test_midrun_reset();
        en = 2'b11; mode = 4'b1100; sat = '0;
        load = 2'b01; load_val = {4'd0, 4'd9};
        tick();
        rst = 1'b1; load = 2'b11; load_val = {4'd5, 4'd3}; mode = 4'b0000;
        tick();
        vectors++;
        if (count_o !== 8'hF0 || dir_o !== 2'b01 || tc_o !== 2'b00 || count_o !== exp_count) begin
            miscompares++;
            $display("FAIL midrun_reset: count=%h dir=%b tc=%b, want count=f0 dir=01 tc=00",
                     count_o, dir_o, tc_o);
        end
        rst = 1'b0; load = 2'b10; load_val = {4'd6, 4'd0};
        tick();
        load = '0;
        for (int i = 0; i < 8; i++) begin
            en   = (i % 2 == 0) ? 2'b11 : 2'b01;
            mode = (i % 2 == 0) ? 4'b1100 : 4'b0100;
            tick();
            vectors++;
            if (count_o !== exp_count || dir_o !== exp_dir || tc_o !== exp_tc ||
                count_o[7:4] !== 4'd6) begin
                miscompares++;
                $display("FAIL hold_ch1[%0d]: count=%h dir=%b tc=%b, want count=%h (count1=6) dir=%b tc=%b",
                         i, count_o, dir_o, tc_o, exp_count, exp_dir, exp_tc);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 49) == 0);
            en       = CH'($urandom);
            mode     = (2*CH)'($urandom);
            sat      = CH'($urandom);
            for (int c = 0; c < CH; c++) load[c] = ($urandom_range(0, 7) == 0);
            load_val = (W*CH)'($urandom);
            tick();
            vectors++;
            if (count_o !== exp_count || dir_o !== exp_dir || tc_o !== exp_tc) begin
                miscompares++;
                $display("FAIL random[%0d]: count=%h dir=%b tc=%b, want count=%h dir=%b tc=%b",
                         i, count_o, dir_o, tc_o, exp_count, exp_dir, exp_tc);
            end
        end
        rst = 1'b0; load = '0; en = '0;
    endtask

    initial begin
        rst = 1'b1; en = '0; mode = '0; sat = '0; load = '0; load_val = '0;
        @(negedge clk);
        test_reset();
        test_wrap();
        test_saturate();
        test_bounce();
        test_load_priority();
        test_midrun_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
